// File: rtl/band_scale_mc.sv
// Time-multiplexed band scaler: squares each pot to a gain, scales its audio band and saturates.
// Optional per-band gain slew limiting is compiled in with BAND_SCALE_SMOOTH_EN.
module band_scale_mc #(
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 16,
    parameter int POT_W     = 12,
    parameter int SHIFT     = 10,
    parameter int SLEW_STEP = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [NUM_BANDS*POT_W-1:0]    pot_in,
    input  logic [NUM_BANDS*DATA_W-1:0]   audio_in,
    output logic [NUM_BANDS*DATA_W-1:0]   scaled_out,
    output logic [NUM_BANDS-1:0]          sat_flag,
    output logic                          valid_out,
    output logic                          busy,
    output logic                          overrun
);

    // state | meaning
    // IDLE  | waiting for a frame strobe; frame registers hold the last frame
    // RUN   | issuing one band per cycle into the squarer (stage 1)
    // FLUSH | last band retires through the multiplier (stage 2)

    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int PROD_W = DATA_W + POT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic accept, issue;

    logic [NUM_BANDS*POT_W-1:0]  pot_q;
    logic [NUM_BANDS*DATA_W-1:0] audio_q;

    logic [POT_W-1:0]   pot_cur;
    logic [2*POT_W-1:0] pot_sq;
    logic [POT_W-1:0]   g_tgt;
    logic [POT_W-1:0]   g_eff_nxt;

    logic               s1_valid;
    logic [IDX_W-1:0]   s1_idx;
    logic [POT_W-1:0]   s1_g;

    logic signed [DATA_W-1:0] aud_cur;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] res_wide;
    logic                     sat_hi, sat_lo;
    logic [DATA_W-1:0]        res;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_in) begin
                    accept    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            pot_q   <= '0;
            audio_q <= '0;
        end else if (accept) begin
            pot_q   <= pot_in;
            audio_q <= audio_in;
        end
    end

    // Stage 1: shared squarer, keep the top POT_W bits of pot^2 as the gain.
    assign pot_cur = pot_q[idx*POT_W +: POT_W];
    assign pot_sq  = pot_cur * pot_cur;
    assign g_tgt   = POT_W'(pot_sq >> POT_W);

`ifdef BAND_SCALE_SMOOTH_EN
    localparam logic [POT_W-1:0] SLEW = POT_W'(SLEW_STEP);

    logic [POT_W-1:0] gain_q [NUM_BANDS];
    logic [POT_W-1:0] g_cur;

    assign g_cur = gain_q[idx];

    always_comb begin
        g_eff_nxt = g_tgt;
        if (g_tgt >= g_cur) begin
            if ((g_tgt - g_cur) > SLEW) begin
                g_eff_nxt = g_cur + SLEW;
            end
        end else begin
            if ((g_cur - g_tgt) > SLEW) begin
                g_eff_nxt = g_cur - SLEW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_q[b] <= '0;
            end
        end else if (issue) begin
            gain_q[idx] <= g_eff_nxt;
        end
    end
`else
    assign g_eff_nxt = g_tgt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_g     <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_idx <= idx;
                s1_g   <= g_eff_nxt;
            end
        end
    end

    // Stage 2: shared multiplier; gain is zero-extended so it multiplies as a positive value.
    assign aud_cur  = $signed(audio_q[s1_idx*DATA_W +: DATA_W]);
    assign prod     = $signed({1'b0, s1_g}) * aud_cur;
    assign res_wide = prod >>> SHIFT;
    assign sat_hi   = (res_wide > SAT_MAX);
    assign sat_lo   = (res_wide < SAT_MIN);

    always_comb begin
        res = res_wide[DATA_W-1:0];
        if (sat_hi) begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sat_lo) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scaled_out <= '0;
            sat_flag   <= '0;
            valid_out  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid_out <= (state == ST_FLUSH);
            if (valid_in && busy) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                sat_flag <= '0;
            end else if (s1_valid) begin
                scaled_out[s1_idx*DATA_W +: DATA_W] <= res;
                if (sat_hi || sat_lo) begin
                    sat_flag[s1_idx] <= 1'b1;
                end
            end
        end
    end

endmodule
